// File: rtl/mem_stage_sram_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_sram_ctrl
//
// MEM-stage data-memory controller for the pipelined MIPS core. It turns one
// 32-bit load or store from the EX/MEM register into two 16-bit accesses on
// the board's asynchronous SRAM. The low halfword goes first, then the high
// halfword. While an access is in flight, `ready` is held low so the pipeline
// freezes.
//
// Parameters
//   BASE_ADDR  byte address that maps to SRAM word 0
//   SRAM_WAIT  cycles spent on each 16-bit half access (1..15)
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   MEM_R_EN        load request
//   MEM_W_EN        store request (wins when both enables are high)
//   ALU_result      byte address of the access
//   Store_value     store data
//   Mem_read_value  most recent load result (registered)
//   ready           high when the stage is not stalling
//   SRAM_DQ         bidirectional SRAM data bus
//   SRAM_ADDR       SRAM halfword address
//   SRAM_WE_N       SRAM write enable (active low)
//   SRAM_OE_N       SRAM output enable (active low)
//   SRAM_CE_N, SRAM_UB_N, SRAM_LB_N   tied low
// ---------------------------------------------------------------------------
module mem_stage_sram_ctrl #(
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned SRAM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] Store_value,
    output logic [31:0] Mem_read_value,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(SRAM_WAIT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wcnt;
    logic        last;
    logic        req;

    // Operation latched in IDLE; held for the whole access
    logic        op_wr;
    logic [16:0] idx;
    logic [31:0] wdata;
    logic        op_nxt;
    logic [16:0] idx_nxt;
    logic [31:0] wdata_nxt;

    // Registered SRAM-side outputs
    logic        we_n_q;
    logic        oe_n_q;
    logic        dq_oe_q;
    logic [17:0] addr_q;
    logic [15:0] dq_out_q;

    // Byte address -> SRAM word index. Anything outside the window simply
    // wraps modulo 2^17; there is no range error.
    function automatic logic [16:0] word_index(input logic [31:0] byte_addr);
        logic [31:0] off;
        off = byte_addr - 32'(BASE_ADDR);
        return off[18:2];
    endfunction

    assign req  = MEM_R_EN | MEM_W_EN;
    assign last = (wcnt == WAIT_LAST);

    // The stall starts in the very cycle the request shows up in IDLE.
    assign ready = ((state == IDLE) && !req) || (state == DONE);

    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'bz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    // Next-state / latch-next decode
    always_comb begin
        state_nxt = state;
        op_nxt    = op_wr;
        idx_nxt   = idx;
        wdata_nxt = wdata;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = ACC_LO;
                    op_nxt    = MEM_W_EN;
                    idx_nxt   = word_index(ALU_result);
                    wdata_nxt = Store_value;
                end
            end
            ACC_LO:  if (last) state_nxt = ACC_HI;
            ACC_HI:  if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM, latches, read capture and registered SRAM outputs. The SRAM
    // controls are loaded from the next state, so in every cycle they reflect
    // the current registered state without any input-to-output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wcnt           <= 4'd0;
            op_wr          <= 1'b0;
            idx            <= 17'd0;
            wdata          <= 32'd0;
            Mem_read_value <= 32'd0;
            we_n_q         <= 1'b1;
            oe_n_q         <= 1'b1;
            dq_oe_q        <= 1'b0;
            addr_q         <= 18'd0;
            dq_out_q       <= 16'd0;
        end else begin
            state <= state_nxt;
            op_wr <= op_nxt;
            idx   <= idx_nxt;
            wdata <= wdata_nxt;

            if ((state == ACC_LO) || (state == ACC_HI))
                wcnt <= last ? 4'd0 : wcnt + 4'd1;
            else
                wcnt <= 4'd0;

            // Loads sample the bus on the final cycle of each half
            if (!op_wr && last) begin
                if (state == ACC_LO) Mem_read_value[15:0]  <= SRAM_DQ;
                if (state == ACC_HI) Mem_read_value[31:16] <= SRAM_DQ;
            end

            case (state_nxt)
                ACC_LO: begin
                    addr_q   <= {idx_nxt, 1'b0};
                    we_n_q   <= !op_nxt;
                    oe_n_q   <= op_nxt;
                    dq_oe_q  <= op_nxt;
                    dq_out_q <= wdata_nxt[15:0];
                end
                ACC_HI: begin
                    addr_q   <= {idx_nxt, 1'b1};
                    we_n_q   <= !op_nxt;
                    oe_n_q   <= op_nxt;
                    dq_oe_q  <= op_nxt;
                    dq_out_q <= wdata_nxt[31:16];
                end
                default: begin
                    addr_q   <= 18'd0;
                    we_n_q   <= 1'b1;
                    oe_n_q   <= 1'b1;
                    dq_oe_q  <= 1'b0;
                    dq_out_q <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_sram_ctrl
//
// Directed bench for mem_stage_sram_ctrl. Instance `dut` (SRAM_WAIT=1) runs
// against a behavioural SRAM array; instance `dut3` (SRAM_WAIT=3) runs
// against a read-only model whose data is the bitwise inverse of the address.
// ---------------------------------------------------------------------------
module tb_mem_stage_sram_ctrl;

    logic        clk;
    logic        rst;

    // SRAM_WAIT = 1 instance
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_result;
    logic [31:0] store_value;
    wire  [31:0] mem_read_value;
    wire         ready;
    wire  [15:0] sram_dq;
    wire  [17:0] sram_addr;
    wire         we_n, oe_n, ce_n, ub_n, lb_n;

    // SRAM_WAIT = 3 instance
    logic        mem_r_en3;
    logic        mem_w_en3;
    logic [31:0] alu_result3;
    logic [31:0] store_value3;
    wire  [31:0] mem_read_value3;
    wire         ready3;
    wire  [15:0] sram_dq3;
    wire  [17:0] sram_addr3;
    wire         we_n3, oe_n3, ce_n3, ub_n3, lb_n3;

    logic        tb_drv;
    int          n_tests;
    int          n_fail;
    int          low;
    logic        saw_we;

    logic [15:0] sram [0:262143];

    mem_stage_sram_ctrl #(.BASE_ADDR(1024), .SRAM_WAIT(1)) dut (
        .clk(clk), .rst(rst),
        .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en),
        .ALU_result(alu_result), .Store_value(store_value),
        .Mem_read_value(mem_read_value), .ready(ready),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
        .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    mem_stage_sram_ctrl #(.BASE_ADDR(1024), .SRAM_WAIT(3)) dut3 (
        .clk(clk), .rst(rst),
        .MEM_R_EN(mem_r_en3), .MEM_W_EN(mem_w_en3),
        .ALU_result(alu_result3), .Store_value(store_value3),
        .Mem_read_value(mem_read_value3), .ready(ready3),
        .SRAM_DQ(sram_dq3), .SRAM_ADDR(sram_addr3),
        .SRAM_WE_N(we_n3), .SRAM_OE_N(oe_n3),
        .SRAM_CE_N(ce_n3), .SRAM_UB_N(ub_n3), .SRAM_LB_N(lb_n3)
    );

    // SRAM model for dut: write on the clock while WE_N is low, read
    // combinationally while OE_N is low.
    always @(posedge clk) begin
        if (!we_n) sram[sram_addr] <= sram_dq;
    end
    assign sram_dq = (!oe_n) ? sram[sram_addr] : 16'hzzzz;
    // Probe driver: only used while the DUT is expected to have released the bus
    assign sram_dq = tb_drv ? 16'h5A5A : 16'hzzzz;

    // Read-only model for dut3
    assign sram_dq3 = (!oe_n3) ? ~sram_addr3[15:0] : 16'hzzzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on dut, held for the first cycle only; returns in DONE.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int lo, output logic swe);
        mem_r_en    = r;
        mem_w_en    = w;
        alu_result  = a;
        store_value = d;
        #1;
        lo  = 0;
        swe = 1'b0;
        while (ready !== 1'b1 && lo < 50) begin
            lo++;
            @(posedge clk);
            #1;
            mem_r_en = 1'b0;
            mem_w_en = 1'b0;
            #1;
            if (we_n === 1'b0) swe = 1'b1;
        end
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        tb_drv       = 1'b0;
        rst          = 1'b1;
        mem_r_en     = 1'b0;
        mem_w_en     = 1'b0;
        alu_result   = 32'd0;
        store_value  = 32'd0;
        mem_r_en3    = 1'b0;
        mem_w_en3    = 1'b0;
        alu_result3  = 32'd0;
        store_value3 = 32'd0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_rdval", mem_read_value, 0);
        chk("rst_we_n", we_n, 1);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_addr", sram_addr, 0);
        chk("rst_ties", {ce_n, ub_n, lb_n, ce_n3, ub_n3, lb_n3}, 0);
        chk("rst_ready3", ready3, 1);
        tb_drv = 1'b1;
        #1;
        chk("rst_bus_released", sram_dq, 32'h5A5A);
        tb_drv = 1'b0;
        #1;

        // Store 0xDEADBEEF at 1028 (word 1)
        mem_w_en    = 1'b1;
        alu_result  = 32'd1028;
        store_value = 32'hDEADBEEF;
        #1;
        chk("st_t_ready", ready, 0);
        tick();
        mem_w_en = 1'b0;
        #1;
        chk("st_lo_addr", sram_addr, 2);
        chk("st_lo_dq", sram_dq, 32'hBEEF);
        chk("st_lo_we_n", we_n, 0);
        chk("st_lo_ready", ready, 0);
        tick();
        chk("st_hi_addr", sram_addr, 3);
        chk("st_hi_dq", sram_dq, 32'hDEAD);
        chk("st_hi_we_n", we_n, 0);
        chk("st_hi_ready", ready, 0);
        tick();
        chk("st_done_ready", ready, 1);
        chk("st_done_we_n", we_n, 1);
        tick();

        // Load it back
        access(1'b1, 1'b0, 32'd1028, 32'h0, low, saw_we);
        chk("ld_low_cycles", low, 3);
        chk("ld_value", mem_read_value, 32'hDEADBEEF);
        chk("ld_no_write", saw_we, 0);
        tick();

        // Store word 0, then word 2 with both enables high
        access(1'b0, 1'b1, 32'd1024, 32'h11112222, low, saw_we);
        chk("st0_low_cycles", low, 3);
        chk("st0_rdval_kept", mem_read_value, 32'hDEADBEEF);
        tick();
        access(1'b1, 1'b1, 32'd1032, 32'h33334444, low, saw_we);
        chk("both_en_wrote", saw_we, 1);
        tick();

        // Back-to-back loads of words 0 and 2
        access(1'b1, 1'b0, 32'd1024, 32'h0, low, saw_we);
        chk("b2b_a_low", low, 3);
        chk("b2b_a_value", mem_read_value, 32'h11112222);
        tick();
        access(1'b1, 1'b0, 32'd1032, 32'h0, low, saw_we);
        chk("b2b_b_low", low, 3);
        chk("b2b_b_value", mem_read_value, 32'h33334444);
        tick();

        // Reset during ACC_LO of a store
        mem_w_en    = 1'b1;
        alu_result  = 32'd1040;
        store_value = 32'hAAAABBBB;
        tick();
        mem_w_en = 1'b0;
        #1;
        chk("rmid_lo_we_n", we_n, 0);
        chk("rmid_lo_addr", sram_addr, 8);
        rst = 1'b1;
        tick();
        chk("rmid_we_n", we_n, 1);
        chk("rmid_oe_n", oe_n, 1);
        chk("rmid_ready", ready, 1);
        chk("rmid_rdval", mem_read_value, 0);
        chk("rmid_addr", sram_addr, 0);
        tb_drv = 1'b1;
        #1;
        chk("rmid_bus_released", sram_dq, 32'h5A5A);
        tb_drv = 1'b0;
        rst    = 1'b0;
        tick();

        // Address below BASE_ADDR wraps to word 0x1FFFF
        mem_w_en    = 1'b1;
        alu_result  = 32'd1020;
        store_value = 32'h55556666;
        tick();
        mem_w_en = 1'b0;
        #1;
        chk("wrap_lo_addr", sram_addr, 32'h3FFFE);
        chk("wrap_lo_dq", sram_dq, 32'h6666);
        tick();
        chk("wrap_hi_addr", sram_addr, 32'h3FFFF);
        chk("wrap_hi_dq", sram_dq, 32'h5555);
        tick();
        tick();
        access(1'b1, 1'b0, 32'd1020, 32'h0, low, saw_we);
        chk("wrap_ld_value", mem_read_value, 32'h55556666);
        tick();

        // SRAM_WAIT = 3 load at 1024: each halfword held 3 cycles, 7 stall cycles
        mem_r_en3   = 1'b1;
        alu_result3 = 32'd1024;
        #1;
        low = (ready3 === 1'b0) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            mem_r_en3 = 1'b0;
            #1;
            chk("w3_lo_addr", sram_addr3, 0);
            chk("w3_lo_oe_n", oe_n3, 0);
            if (ready3 === 1'b0) low++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("w3_hi_addr", sram_addr3, 1);
            if (ready3 === 1'b0) low++;
        end
        tick();
        chk("w3_done_ready", ready3, 1);
        chk("w3_low_cycles", low, 7);
        chk("w3_value", mem_read_value3, 32'hFFFEFFFF);
        chk("w3_done_oe_n", oe_n3, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Data-memory access controller for the MEM stage of the pipelined MIPS core. It translates one 32-bit load or store from the EX/MEM register into two 16-bit accesses on the board's external asynchronous SRAM. While the access is in flight it drives `ready` low, which the pipeline uses as its freeze signal. Its `Mem_read_value` output feeds the MEM/WB stage register, which captures it when `ready` returns high.

## Interface
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.
- `SRAM_WAIT`, default 1, range 1–15: cycles spent on each 16-bit half access.

- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `MEM_R_EN`, in, 1: load request from the EX/MEM register.
- `MEM_W_EN`, in, 1: store request from the EX/MEM register.
- `ALU_result`, in, 32: byte address of the access.
- `Store_value`, in, 32: store data.
- `Mem_read_value`, out, 32: most recent load result, registered.
- `ready`, out, 1: high when the stage is not stalling; pipeline freeze = `!ready`.
- `SRAM_DQ`, inout, 16: SRAM data bus.
- `SRAM_ADDR`, out, 18: SRAM halfword address.
- `SRAM_WE_N`, out, 1: write enable, active low.
- `SRAM_OE_N`, out, 1: output enable, active low.
- `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`, out, 1 each: tied 0.

## Operation
- State machine states: IDLE, ACC_LO, ACC_HI, DONE. A 4-bit counter `wcnt` times each half access.
- Request: `req = MEM_R_EN | MEM_W_EN`. If both are high, the access is a write.
- IDLE
  - On `req`: latch `op`, the word index and `Store_value`; clear `wcnt`; go to ACC_LO.
  - No `req`: stay in IDLE.
- Word index: `(ALU_result - BASE_ADDR) >> 2`, truncated to 17 bits. Out-of-range addresses wrap modulo 2^17; there is no error flag.
- ACC_LO
  - `SRAM_ADDR = {idx, 1'b0}`.
  - Write: drive `SRAM_DQ = wdata[15:0]`, `SRAM_WE_N = 0`.
  - Read: `SRAM_OE_N = 0`, `SRAM_DQ` high-Z.
  - `wcnt` increments each cycle. When `wcnt == SRAM_WAIT-1`: a read captures `SRAM_DQ` into `Mem_read_value[15:0]`; clear `wcnt`; go to ACC_HI.
- ACC_HI: same as ACC_LO using `{idx, 1'b1}` and bits [31:16]. On the last cycle, go to DONE.
- DONE: `ready = 1`. Go to IDLE unconditionally; the request seen in the following IDLE cycle belongs to the next instruction.
- `ready = (state==IDLE && !req) || state==DONE`. This is combinational, so the stall begins in the same cycle the request appears.
- `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_ADDR` and the `SRAM_DQ` drive-enable are decoded from registered state only, with no input-to-output path.
- Outside the access states: `SRAM_WE_N = 1`, `SRAM_OE_N = 1`, `SRAM_DQ` high-Z, `SRAM_ADDR = 0`.
- A write leaves `Mem_read_value` unchanged. Mixing the halves of two different words is impossible, because the address and data are latched in IDLE.

## Timing
- Reset values
  - state = IDLE, `wcnt = 0`, `Mem_read_value = 0`, latched address/data = 0.
  - Outputs: `ready = 1` (absent a request), `SRAM_WE_N = 1`, `SRAM_OE_N = 1`, `SRAM_ADDR = 0`, `SRAM_DQ` high-Z.
- Request first seen in cycle t, with W = `SRAM_WAIT`:
  - ACC_LO in cycles t+1 … t+W.
  - ACC_HI in cycles t+W+1 … t+2W.
  - DONE in cycle t+2W+1.
- `ready` is low for 2W+1 cycles (t … t+2W). With W=1 it is low for 3 cycles and high in t+3.
- `Mem_read_value` is final from the DONE cycle onward and is stable at the MEM/WB capture edge.
- Back-to-back requests: DONE → IDLE → new access. One idle cycle separates accesses, and `ready` is high only in DONE.
- Reset mid-access: at the next edge, state goes to IDLE, `SRAM_WE_N` goes high and the bus is released. `Mem_read_value` clears to 0. A partially written word is left in SRAM as is.
- A request that drops while the FSM is busy is ignored; the latched operation completes.

## Test plan
- **Reset:** hold `rst` 2 cycles, no request → `ready = 1`, `Mem_read_value = 0`, `SRAM_WE_N = 1`, `SRAM_OE_N = 1`, `SRAM_DQ` = Z.
- **Store:** `MEM_W_EN = 1`, `ALU_result = 1028`, `Store_value = 0xDEADBEEF`, W=1 →
  - cycle t+1: `SRAM_ADDR = 2`, `DQ = 0xBEEF`, `WE_N = 0`;
  - cycle t+2: `SRAM_ADDR = 3`, `DQ = 0xDEAD`;
  - `ready` low for exactly 3 cycles.
- **Load after store:** `MEM_R_EN = 1`, `ALU_result = 1028` against an SRAM model → `Mem_read_value = 0xDEADBEEF` in DONE; `WE_N` stays 1 throughout.
- **Wait states:** `SRAM_WAIT = 3` load → `ready` low for 7 cycles; each halfword address is held for 3 cycles.
- **Back-to-back loads** at 1024 and 1032 → two 3-cycle stalls separated by one idle cycle; reads return words 0 and 2 in order.
- **Edge cases:**
  - `rst` asserted in ACC_LO of a store → next cycle `WE_N = 1`, bus Z, `ready = 1`.
  - Both enables high → write performed.
  - `ALU_result = 1020` → wraps to word index 0x1FFFF.
